// File: rtl/vehicle_emulator_if.sv
// Handshake bundle between a vehicle-emulator controller (master) and the emulator (slave).
// The master issues trigger/gap/abort; the slave returns the two sensor lines and run status.
interface vehicle_emulator_if #(
    parameter int WIDTH = 32
);
    logic             trigger;
    logic [WIDTH-1:0] gap;
    logic             abort;
    logic             sensor1;
    logic             sensor2;
    logic             ready;
    logic             done;
    logic             err;

    modport master (
        output trigger, gap, abort,
        input  sensor1, sensor2, ready, done, err
    );

    modport slave (
        input  trigger, gap, abort,
        output sensor1, sensor2, ready, done, err
    );
endinterface

// File: rtl/vehicle_emulator.sv
// Emulates a vehicle crossing two road sensors: a sensor1 pulse, then a sensor2 pulse
// exactly gap cycles later, each PULSE_LEN cycles wide, followed by a one-cycle done.
module vehicle_emulator #(
    parameter int WIDTH     = 32,
    parameter int PULSE_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    vehicle_emulator_if.slave bus
);
    localparam int PCW = $clog2(PULSE_LEN + 1);
    localparam logic [PCW-1:0] PULSE_INIT = PCW'(PULSE_LEN);

    typedef enum logic [1:0] {IDLE, RUN, TAIL, DONE} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] gap_q, gap_q_d;
    logic [WIDTH-1:0] gap_cnt, gap_cnt_d;
    logic [PCW-1:0]   s1_cnt, s1_cnt_d;
    logic [PCW-1:0]   s2_cnt, s2_cnt_d;
    logic             accept;
    logic             err_d;

    // Counters hold the remaining high cycles of each line; outputs are registered from the
    // next-state values so every output changes exactly on the edge that decides it.
    always_comb begin
        state_d   = state;
        gap_q_d   = gap_q;
        gap_cnt_d = gap_cnt;
        s1_cnt_d  = (s1_cnt != '0) ? s1_cnt - PCW'(1) : '0;
        s2_cnt_d  = s2_cnt;
        accept    = 1'b0;
        err_d     = 1'b0;

        case (state)
            IDLE: begin
                accept = bus.trigger && !bus.abort;
            end
            RUN: begin
                if (bus.abort) begin
                    state_d  = IDLE;
                    s1_cnt_d = '0;
                end else if (gap_cnt == gap_q) begin
                    s2_cnt_d = PULSE_INIT;
                    state_d  = TAIL;
                end else begin
                    gap_cnt_d = gap_cnt + WIDTH'(1);
                end
            end
            TAIL: begin
                if (bus.abort) begin
                    state_d  = IDLE;
                    s1_cnt_d = '0;
                    s2_cnt_d = '0;
                end else begin
                    s2_cnt_d = s2_cnt - PCW'(1);
                    if (s2_cnt == PCW'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                accept  = bus.trigger;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A zero gap cannot describe a transit, so it is rejected without leaving idle.
        if (accept) begin
            gap_q_d = bus.gap;
            if (bus.gap == '0) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                state_d   = RUN;
                gap_cnt_d = WIDTH'(1);
                s1_cnt_d  = PULSE_INIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gap_q       <= '0;
            gap_cnt     <= '0;
            s1_cnt      <= '0;
            s2_cnt      <= '0;
            bus.sensor1 <= 1'b0;
            bus.sensor2 <= 1'b0;
            bus.ready   <= 1'b1;
            bus.done    <= 1'b0;
            bus.err     <= 1'b0;
        end else begin
            state       <= state_d;
            gap_q       <= gap_q_d;
            gap_cnt     <= gap_cnt_d;
            s1_cnt      <= s1_cnt_d;
            s2_cnt      <= s2_cnt_d;
            bus.sensor1 <= (s1_cnt_d != '0);
            bus.sensor2 <= (s2_cnt_d != '0);
            bus.ready   <= (state_d == IDLE) || (state_d == DONE);
            bus.done    <= (state_d == DONE);
            bus.err     <= err_d;
        end
    end
endmodule

// File: tb/tb_vehicle_emulator.sv
// Scoreboard bench for vehicle_emulator: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_vehicle_emulator;
    localparam int W = 32;
    localparam int P = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic finishing = 1'b0;
    logic mon_done = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vehicle_emulator_if #(.WIDTH(W)) vif();

    vehicle_emulator #(.WIDTH(W), .PULSE_LEN(P)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (vif.slave)
    );

    typedef struct {
        int         cyc;
        logic [4:0] v;
        string      name;
    } exp_t;

    exp_t sb[$];

    // Vector order: {sensor1, sensor2, ready, done, err}
    always @(negedge clk) begin
        logic [4:0] act;
        act = {vif.sensor1, vif.sensor2, vif.ready, vif.done, vif.err};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc || act !== e.v) begin
                failures++;
                $display("FAIL %s cycle %0d: got {s1,s2,rdy,done,err}=%b expected %b (for cycle %0d)",
                         e.name, cyc, act, e.v, e.cyc);
            end
        end
        if (finishing && !mon_done) begin
            checks++;
            if (sb.size() != 0) begin
                failures++;
                $display("FAIL scoreboard_drain: got %0d unchecked entries expected 0", sb.size());
            end
            mon_done = 1'b1;
        end
    end

    function automatic logic [4:0] model(input int i, input int g);
        return {(i < P), (i >= g && i < g + P), (i == g + P), (i == g + P), 1'b0};
    endfunction

    task automatic push(input int c, input logic [4:0] v, input string nm);
        exp_t e;
        e.cyc = c;
        e.v = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic push_run(input int t0, input int g, input int last, input string nm);
        for (int i = 0; i <= last; i++) push(t0 + i, model(i, g), nm);
    endtask

    task automatic push_idle(input int from, input int n, input string nm);
        for (int i = 0; i < n; i++) push(from + i, 5'b00100, nm);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) next_cycle();
    endtask

    task automatic fire(input int g, output int t0);
        vif.gap = W'(g);
        vif.trigger = 1'b1;
        t0 = cyc + 1;
    endtask

    initial begin
        int t0;
        int t1;
        vif.trigger = 1'b0;
        vif.gap = '0;
        vif.abort = 1'b0;

        next_cycle();
        next_cycle();
        push(cyc, 5'b00100, "reset_state");
        push(cyc + 1, 5'b00100, "reset_state");
        next_cycle();
        rst_n = 1'b1;
        push_idle(cyc + 1, 2, "post_reset_idle");
        next_cycle();
        next_cycle();

        // 1: nominal gap, gap input changed after accept
        fire(10, t0);
        push_run(t0, 10, 10 + P, "run_gap10");
        push(t0 + 10 + P + 1, 5'b00100, "run_gap10_after");
        next_cycle();
        vif.trigger = 1'b0;
        vif.gap = W'(3);
        wait_to(t0 + 10 + P + 3);

        // 2: overlapping pulses
        fire(2, t0);
        push_run(t0, 2, 2 + P, "overlap_gap2");
        next_cycle();
        vif.trigger = 1'b0;
        wait_to(t0 + 2 + P + 3);

        // 3: zero gap rejected
        fire(0, t0);
        push(t0, 5'b00101, "gap0_err");
        push_idle(t0 + 1, 3, "gap0_quiet");
        next_cycle();
        vif.trigger = 1'b0;
        wait_to(t0 + 6);

        // 4: ignored retrigger while busy, then abort
        fire(20, t0);
        push_run(t0, 20, 7, "abort_run");
        push_idle(t0 + 8, 22, "abort_idle");
        next_cycle();
        vif.trigger = 1'b0;
        wait_to(t0 + 3);
        vif.trigger = 1'b1;
        vif.gap = W'(5);
        next_cycle();
        vif.trigger = 1'b0;
        wait_to(t0 + 7);
        vif.abort = 1'b1;
        next_cycle();
        vif.abort = 1'b0;
        wait_to(t0 + 32);

        // abort and trigger together in idle: trigger dropped
        vif.abort = 1'b1;
        vif.trigger = 1'b1;
        vif.gap = W'(5);
        push_idle(cyc + 1, 4, "abort_beats_trigger");
        next_cycle();
        vif.abort = 1'b0;
        vif.trigger = 1'b0;
        wait_to(cyc + 5);

        // 5: trigger held high, back-to-back acceptance in the done cycle
        fire(1, t0);
        push_run(t0, 1, 1 + P, "b2b_first");
        push_run(t0 + 6, 1, 1 + P, "b2b_second");
        push_idle(t0 + 12, 2, "b2b_end");
        wait_to(t0 + 11);
        vif.trigger = 1'b0;
        wait_to(t0 + 15);

        // 6: asynchronous reset during sensor2, then a fresh run
        fire(8, t0);
        push_run(t0, 8, 8, "reset_mid_run");
        push(t0 + 9, 5'b00100, "async_reset_now");
        push(t0 + 10, 5'b00100, "async_reset_held");
        push(t0 + 11, 5'b00100, "async_reset_held");
        push_idle(t0 + 12, 2, "after_reset_idle");
        next_cycle();
        vif.trigger = 1'b0;
        wait_to(t0 + 9);
        rst_n = 1'b0;
        wait_to(t0 + 11);
        rst_n = 1'b1;
        wait_to(t0 + 13);
        fire(3, t1);
        push_run(t1, 3, 3 + P, "after_reset_gap3");
        next_cycle();
        vif.trigger = 1'b0;
        wait_to(t1 + 3 + P + 3);

        finishing = 1'b1;
        for (int i = 0; i < 10 && !mon_done; i++) next_cycle();
        if (!mon_done) begin
            $display("FAIL monitor_finish: got no drain check expected one");
            $fatal(1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
